// File: rtl/hilo_divider.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hilo_divider: multi-cycle restoring divider, signed/unsigned, {rem, quot}   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module hilo_divider #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic               cancel,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  output logic               busy,
  output logic               valid,
  output logic               div_by_zero,
  output logic [2*WIDTH-1:0] hilo
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [CNTW-1:0] c_lastIter = CNTW'(WIDTH - 1);

  state_t             r_state, w_nextState;
  logic [WIDTH-1:0]   r_opa, r_opb, r_quot, r_rem, r_div;
  logic               r_signed, r_negQ, r_negR, r_zeroPend, r_divByZero;
  logic [CNTW-1:0]    r_cnt;
  logic [2*WIDTH-1:0] r_hilo;
  logic               w_accept, w_opaNeg, w_opbNeg;
  logic [WIDTH:0]     w_remShift, w_diff;

  assign w_accept   = ((r_state == IDLE) || (r_state == DONE)) && start && !cancel;
  assign w_opaNeg   = r_signed && r_opa[WIDTH-1];
  assign w_opbNeg   = r_signed && r_opb[WIDTH-1];
  assign w_remShift = {r_rem, r_quot[WIDTH-1]};
  assign w_diff     = w_remShift - {1'b0, r_div};

  // A zero divisor borrows the FIX slot so its result still lands two edges after acceptance
  always_comb begin
    w_nextState = r_state;
    if (cancel) begin
      w_nextState = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (start) w_nextState = PREP;
        PREP:    w_nextState = (r_opb == '0) ? FIX : ITER;
        ITER:    if (r_cnt == c_lastIter) w_nextState = FIX;
        FIX:     w_nextState = DONE;
        DONE:    w_nextState = start ? PREP : IDLE;
        default: w_nextState = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_opa       <= '0;
      r_opb       <= '0;
      r_signed    <= 1'b0;
      r_quot      <= '0;
      r_rem       <= '0;
      r_div       <= '0;
      r_negQ      <= 1'b0;
      r_negR      <= 1'b0;
      r_zeroPend  <= 1'b0;
      r_cnt       <= '0;
      r_hilo      <= '0;
      r_divByZero <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_opa    <= opa;
        r_opb    <= opb;
        r_signed <= signed_div;
      end
      if (!cancel) begin
        case (r_state)
          PREP: begin
            r_quot     <= w_opaNeg ? -r_opa : r_opa;
            r_div      <= w_opbNeg ? -r_opb : r_opb;
            r_rem      <= '0;
            r_negQ     <= w_opaNeg ^ w_opbNeg;
            r_negR     <= w_opaNeg;
            r_zeroPend <= (r_opb == '0);
            r_cnt      <= '0;
          end
          ITER: begin
            // Dividend bits shift out of the quotient register as quotient bits shift in
            if (!w_diff[WIDTH]) begin
              r_rem  <= w_diff[WIDTH-1:0];
              r_quot <= {r_quot[WIDTH-2:0], 1'b1};
            end else begin
              r_rem  <= w_remShift[WIDTH-1:0];
              r_quot <= {r_quot[WIDTH-2:0], 1'b0};
            end
            r_cnt <= r_cnt + 1'b1;
          end
          FIX: begin
            if (r_zeroPend) begin
              r_hilo <= {r_opa, {WIDTH{1'b1}}};
            end else begin
              r_hilo <= {(r_negR ? -r_rem : r_rem), (r_negQ ? -r_quot : r_quot)};
            end
            r_divByZero <= r_zeroPend;
          end
          default: ;
        endcase
      end
    end
  end

  assign busy        = (r_state == PREP) || (r_state == ITER) || (r_state == FIX);
  assign valid       = (r_state == DONE);
  assign div_by_zero = r_divByZero;
  assign hilo        = r_hilo;

endmodule
`default_nettype wire

// File: tb/tb_hilo_divider.sv
`default_nettype none
// Scoreboarded bench for hilo_divider (WIDTH=32): directed vectors, monitor pops on valid.
module tb_hilo_divider;

  localparam int WIDTH = 32;

  logic              clk, rst, start, signed_div, cancel;
  logic [WIDTH-1:0]  opa, opb;
  logic              busy, valid, div_by_zero;
  logic [2*WIDTH-1:0] hilo;

  hilo_divider #(.WIDTH(WIDTH), .CNTW(6)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div), .cancel(cancel),
    .opa(opa), .opb(opb), .busy(busy), .valid(valid), .div_by_zero(div_by_zero),
    .hilo(hilo)
  );

  typedef struct {
    logic [63:0] hilo;
    logic        dbz;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   nVec = 0;
  int   nMis = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every valid strobe must match the oldest outstanding expectation
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (valid === 1'b1) begin
        if (sb.size() == 0) begin
          nVec++;
          nMis++;
          $display("FAIL unexpected_valid: got valid=1 expected no result (cycle %0d)", cyc);
        end else begin
          x = sb.pop_front();
          check("hilo", hilo, x.hilo);
          check("div_by_zero", {63'd0, div_by_zero}, {63'd0, x.dbz});
          check("latency", 64'(cyc), 64'(x.due));
        end
      end
    end
  end

  // Called at a negedge; start is sampled at the following rising edge
  task automatic doOp(input logic [31:0] a, input logic [31:0] b, input logic s,
                      input logic [63:0] e, input logic z, input bit track);
    exp_t x;
    opa = a; opb = b; signed_div = s; start = 1'b1;
    if (track) begin
      x.hilo = e;
      x.dbz  = z;
      x.due  = cyc + 1 + ((b == 32'd0) ? 2 : WIDTH + 2);
      sb.push_back(x);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns at the negedge on which valid is seen, or flags a timeout
  task automatic waitDone();
    bit seen;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (valid === 1'b1) seen = 1;
      else @(negedge clk);
    end
    if (!seen) begin
      nVec++;
      nMis++;
      $display("FAIL timeout: got no valid expected valid within 60 cycles");
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; cancel = 1'b0; signed_div = 1'b0; opa = '0; opb = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_valid", {63'd0, valid}, 64'd0);
    check("rst_dbz", {63'd0, div_by_zero}, 64'd0);
    check("rst_hilo", hilo, 64'd0);

    // First start accepted on the first edge after release
    rst = 1'b1;
    doOp(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 1'b0, 1);
    check("busy_after_accept", {63'd0, busy}, 64'd1);
    waitDone(); @(negedge clk);

    doOp(-32'sd7, 32'd2, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0, 1); waitDone();
    // Back-to-back: start issued in the DONE cycle
    doOp(32'd7, -32'sd2, 1'b1, {32'd1, 32'hFFFFFFFD}, 1'b0, 1); waitDone();
    doOp(32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h0, 32'h80000000}, 1'b0, 1); waitDone(); @(negedge clk);
    doOp(32'hFFFFFFFF, 32'h10, 1'b0, {32'hF, 32'h0FFFFFFF}, 1'b0, 1); waitDone(); @(negedge clk);
    doOp(-32'sd100, 32'd7, 1'b1, {32'hFFFFFFFE, 32'hFFFFFFF2}, 1'b0, 1); waitDone(); @(negedge clk);
    doOp(32'h80000000, 32'd3, 1'b0, {32'd2, 32'h2AAAAAAA}, 1'b0, 1); waitDone(); @(negedge clk);
    doOp(32'd5, 32'd0, 1'b0, {32'd5, 32'hFFFFFFFF}, 1'b1, 1); waitDone(); @(negedge clk);
    doOp(-32'sd5, 32'd0, 1'b1, {32'hFFFFFFFB, 32'hFFFFFFFF}, 1'b1, 1); waitDone(); @(negedge clk);

    // Cancel mid-operation after a completed 100/7
    doOp(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 1'b0, 1); waitDone(); @(negedge clk);
    doOp(32'd50, 32'd3, 1'b0, 64'd0, 1'b0, 0);
    repeat (8) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_busy", {63'd0, busy}, 64'd0);
    check("cancel_hilo", hilo, {32'd2, 32'd14});
    check("cancel_dbz", {63'd0, div_by_zero}, 64'd0);
    repeat (40) @(negedge clk);

    // Cancel wins over a simultaneous start
    start = 1'b1; cancel = 1'b1; opa = 32'd9; opb = 32'd3;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    check("cancel_start_busy", {63'd0, busy}, 64'd0);
    repeat (3) @(negedge clk);

    doOp(32'd50, 32'd3, 1'b0, {32'd2, 32'd16}, 1'b0, 1); waitDone(); @(negedge clk);
    doOp(32'd5, 32'd0, 1'b0, {32'd5, 32'hFFFFFFFF}, 1'b1, 1); waitDone(); @(negedge clk);

    // Asynchronous reset in the middle of ITER
    doOp(32'd1000, 32'd9, 1'b0, 64'd0, 1'b0, 0);
    repeat (13) @(negedge clk);
    check("mid_iter_busy", {63'd0, busy}, 64'd1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_busy", {63'd0, busy}, 64'd0);
    check("async_rst_valid", {63'd0, valid}, 64'd0);
    check("async_rst_hilo", hilo, 64'd0);
    check("async_rst_dbz", {63'd0, div_by_zero}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    doOp(32'd1000, 32'd9, 1'b0, {32'd1, 32'd111}, 1'b0, 1); waitDone();
    repeat (5) @(negedge clk);

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
`default_nettype wire
